rv_multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32I execute datapath.
- Fetches each instruction over a req/ack instruction port and holds it in an instruction register (IR).
- Drives ALU operand-select enable, data-memory handshake, register-file write enable and PC update for one instruction at a time.
- Sits between the instruction/data memory interfaces and the operand-select + ALU + register-file datapath.

---
 rtl/rv_multicycle_ctrl_pkg.sv | 27 ++
 rtl/rv_multicycle_ctrl_if.sv | 35 +++
 rtl/rv_multicycle_ctrl_opcode_class.sv | 24 ++
 rtl/rv_multicycle_ctrl.sv | 123 ++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/rv_multicycle_ctrl_pkg.sv
// rv_ctrl_pkg: shared opcode, state and encoding definitions for the RV32I multicycle controller.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} ctrl_state_t;

    typedef enum logic [2:0] {CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR} op_class_t;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IMEM    = 2'd2;
    localparam logic [1:0] CAUSE_DMEM    = 2'd3;

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// rv_multicycle_ctrl_if: instruction/data memory handshakes and datapath control bundle.
interface rv_multicycle_ctrl_if #(parameter int XLEN = 32);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic [31:0]     ir;
    logic [XLEN-1:0] pc;
    logic            alu_en;
    logic [XLEN-1:0] alu_result;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic            dmem_ack;
    logic            rf_we;
    logic [1:0]      wb_sel;
    logic            trap;
    logic [1:0]      trap_cause;

    modport master (
        output imem_req, imem_addr, ir, pc, alu_en, dmem_req, dmem_we, dmem_addr,
               rf_we, wb_sel, trap, trap_cause,
        input  imem_ack, imem_rdata, alu_result, br_taken, br_target, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, ir, pc, alu_en, dmem_req, dmem_we, dmem_addr,
               rf_we, wb_sel, trap, trap_cause,
        output imem_ack, imem_rdata, alu_result, br_taken, br_target, dmem_ack
    );

endinterface

// File: rtl/rv_multicycle_ctrl_opcode_class.sv
// rv_opcode_class: combinational RV32I major-opcode classifier with legality flag.
module rv_opcode_class
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  cls,
    output logic       legal
);

    always_comb begin
        cls   = CL_ALU;
        legal = 1'b1;
        case (opcode)
            OP_R, OP_I, OP_LUI, OP_AUIPC: cls = CL_ALU;
            OP_LOAD:                      cls = CL_LOAD;
            OP_STORE:                     cls = CL_STORE;
            OP_BRANCH:                    cls = CL_BRANCH;
            OP_JAL:                       cls = CL_JAL;
            OP_JALR:                      cls = CL_JALR;
            default:                      legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for a multicycle RV32I datapath,
// with sticky trap on illegal opcode or memory handshake timeout.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              MEM_TIMEOUT = 255
) (
    input logic clk,
    input logic rst_n,
    rv_multicycle_ctrl_if.master bus
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    ctrl_state_t     state, state_n;
    logic [XLEN-1:0] pc, pc_n, addr, addr_n, pc4;
    logic [31:0]     ir, ir_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      cause, cause_n;
    op_class_t       cls;
    logic            legal, timeout;

    rv_opcode_class u_cls (.opcode(ir[6:0]), .cls(cls), .legal(legal));

    assign pc4     = pc + XLEN'(4);
    assign timeout = (MEM_TIMEOUT != 0) && (cnt == CW'(MEM_TIMEOUT - 1));

    assign bus.imem_addr  = pc;
    assign bus.pc         = pc;
    assign bus.ir         = ir;
    assign bus.dmem_addr  = addr;
    assign bus.trap       = state == TRAP;
    assign bus.trap_cause = cause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
            addr  <= '0;
            cnt   <= '0;
            cause <= CAUSE_NONE;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ir    <= ir_n;
            addr  <= addr_n;
            cnt   <= cnt_n;
            cause <= cause_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        ir_n         = ir;
        addr_n       = addr;
        cause_n      = cause;
        bus.imem_req = 1'b0;
        bus.alu_en   = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        bus.rf_we    = 1'b0;
        bus.wb_sel   = WB_ALU;
        case (state)
            FETCH: begin
                bus.imem_req = 1'b1;
                ir_n    = bus.imem_ack ? bus.imem_rdata : ir;
                state_n = bus.imem_ack ? DECODE : (timeout ? TRAP : FETCH);
                cause_n = (!bus.imem_ack && timeout) ? CAUSE_IMEM : cause;
            end
            DECODE: begin
                state_n = legal ? EXEC : TRAP;
                cause_n = legal ? cause : CAUSE_ILLEGAL;
            end
            EXEC: begin
                bus.alu_en = 1'b1;
                state_n    = FETCH;
                case (cls)
                    CL_ALU: begin
                        bus.rf_we = 1'b1;
                        pc_n      = pc4;
                    end
                    CL_BRANCH: pc_n = bus.br_taken ? bus.br_target : pc4;
                    CL_JAL: begin
                        bus.rf_we  = 1'b1;
                        bus.wb_sel = WB_PC4;
                        pc_n       = bus.br_target;
                    end
                    CL_JALR: begin
                        bus.rf_we  = 1'b1;
                        bus.wb_sel = WB_PC4;
                        pc_n       = {bus.alu_result[XLEN-1:1], 1'b0};
                    end
                    default: begin
                        addr_n  = bus.alu_result;
                        state_n = MEM;
                    end
                endcase
            end
            MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = cls == CL_STORE;
                pc_n    = (bus.dmem_ack && cls == CL_STORE) ? pc4 : pc;
                state_n = bus.dmem_ack ? (cls == CL_STORE ? FETCH : WB) : (timeout ? TRAP : MEM);
                cause_n = (!bus.dmem_ack && timeout) ? CAUSE_DMEM : cause;
            end
            WB: begin
                bus.rf_we  = 1'b1;
                bus.wb_sel = WB_LOAD;
                pc_n       = pc4;
                state_n    = FETCH;
            end
            TRAP:    state_n = TRAP;
            default: state_n = FETCH;
        endcase
        // the wait counter restarts whenever the state changes, so each FETCH/MEM visit starts at zero
        cnt_n = (state_n == state) ? cnt + CW'(1) : '0;
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: table-driven instruction sequence with scoreboard, plus trap/timeout/reset sequences.
module tb_rv_multicycle_ctrl;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] alu;
        logic        tk;
        logic [31:0] tgt;
        int          iw;
        int          dw;
        logic [31:0] pc;
        int          cyc;
        int          rf;
        logic [1:0]  wb;
        int          dreq;
        logic        we;
        logic [31:0] addr;
    } vec_t;

    logic clk, rst_n, rst2;
    int   nvec, nerr;
    logic [31:0] exp_pc;
    vec_t tbl[12];
    vec_t sb[$];

    rv_multicycle_ctrl_if #(.XLEN(32)) bus1();
    rv_multicycle_ctrl_if #(.XLEN(32)) bus2();

    rv_multicycle_ctrl #(.XLEN(32), .RESET_PC(32'h0), .MEM_TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus1.master)
    );

    rv_multicycle_ctrl #(.XLEN(32), .RESET_PC(32'h0), .MEM_TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst2), .bus(bus2.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        vec_t e;
        int w = 0, dw = 0, cyc = 0, rf = 0, alu = 0, dreq = 0;
        logic [1:0] wb = 2'd3;
        logic we = 1'bx;
        logic [31:0] addr = 32'hx, iaddr;
        bit fetched = 0, done = 0;
        sb.push_back(v);
        bus1.imem_rdata = v.instr;
        bus1.alu_result = v.alu;
        bus1.br_taken   = v.tk;
        bus1.br_target  = v.tgt;
        iaddr = bus1.imem_addr;
        for (int c = 0; c < 200 && !done; c++) begin
            if (fetched && bus1.imem_req) done = 1;
            else begin
                cyc++;
                bus1.imem_ack = bus1.imem_req && (w == v.iw);
                if (bus1.imem_req) w++;
                if (bus1.imem_ack) fetched = 1;
                bus1.dmem_ack = bus1.dmem_req && (dw == v.dw);
                if (bus1.dmem_req) begin
                    dw++;
                    dreq++;
                    we   = bus1.dmem_we;
                    addr = bus1.dmem_addr;
                end
                if (bus1.rf_we) begin
                    rf++;
                    wb = bus1.wb_sel;
                end
                if (bus1.alu_en) alu++;
                @(negedge clk);
            end
        end
        bus1.imem_ack = 1'b0;
        bus1.dmem_ack = 1'b0;
        chk("instr_done", 32'(done), 32'd1);
        e = sb.pop_front();
        chk("imem_addr", iaddr, exp_pc);
        chk("ir", bus1.ir, e.instr);
        chk("pc", bus1.pc, e.pc);
        chk("cycles", cyc, e.cyc);
        chk("alu_en_cycles", alu, 1);
        chk("rf_we_cycles", rf, e.rf);
        if (e.rf != 0) chk("wb_sel", 32'(wb), 32'(e.wb));
        chk("dmem_req_cycles", dreq, e.dreq);
        if (e.dreq != 0) begin
            chk("dmem_we", 32'(we), 32'(e.we));
            chk("dmem_addr", addr, e.addr);
        end
        exp_pc = e.pc;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        int rq;
        nvec = 0;
        nerr = 0;
        //          instr         alu           tk tgt           iw dw pc            cyc rf wb dreq we addr
        tbl[0]  = '{32'h00500093, 32'h0,        0, 32'h0,        0, 0, 32'h4,        3,  1, 0, 0,   0, 32'h0};
        tbl[1]  = '{32'h0000A103, 32'h100,      0, 32'h0,        0, 3, 32'h8,        8,  1, 1, 4,   0, 32'h100};
        tbl[2]  = '{32'h0020A023, 32'h104,      0, 32'h0,        2, 0, 32'hC,        6,  0, 0, 1,   1, 32'h104};
        tbl[3]  = '{32'h00000063, 32'h0,        1, 32'h40,       1, 0, 32'h40,       4,  0, 0, 0,   0, 32'h0};
        tbl[4]  = '{32'h00000063, 32'h0,        0, 32'h80,       0, 0, 32'h44,       3,  0, 0, 0,   0, 32'h0};
        tbl[5]  = '{32'h000100E7, 32'h201,      0, 32'h0,        0, 0, 32'h200,      3,  1, 2, 0,   0, 32'h0};
        tbl[6]  = '{32'h002081B3, 32'h55,       1, 32'h300,      3, 0, 32'h204,      6,  1, 0, 0,   0, 32'h0};
        tbl[7]  = '{32'h123450B7, 32'h12345000, 0, 32'h0,        0, 0, 32'h208,      3,  1, 0, 0,   0, 32'h0};
        tbl[8]  = '{32'h00000097, 32'h20C,      0, 32'h0,        0, 0, 32'h20C,      3,  1, 0, 0,   0, 32'h0};
        tbl[9]  = '{32'h040000EF, 32'h0,        0, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 3,  1, 2, 0,   0, 32'h0};
        tbl[10] = '{32'h00500093, 32'h5,        0, 32'h0,        0, 0, 32'h0,        3,  1, 0, 0,   0, 32'h0};
        tbl[11] = '{32'h00500093, 32'h5,        0, 32'h0,        0, 0, 32'h4,        3,  1, 0, 0,   0, 32'h0};
        {bus1.imem_ack, bus1.dmem_ack, bus1.br_taken} = '0;
        {bus1.imem_rdata, bus1.alu_result, bus1.br_target} = '0;
        {bus2.imem_ack, bus2.dmem_ack, bus2.br_taken} = '0;
        {bus2.imem_rdata, bus2.alu_result, bus2.br_target} = '0;
        rst_n = 1'b0;
        rst2  = 1'b0;
        exp_pc = 32'h0;
        #12;
        chk("rst_pc", bus1.pc, 32'h0);
        chk("rst_ir", bus1.ir, 32'h0);
        chk("rst_trap", 32'(bus1.trap), 32'd0);
        chk("rst_cause", 32'(bus1.trap_cause), 32'd0);
        chk("rst_strobes", {29'd0, bus1.alu_en, bus1.rf_we, bus1.dmem_req}, 32'd0);
        chk("rst_wb_sel", 32'(bus1.wb_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) run(tbl[i]);

        // illegal opcode: sticky trap, no more fetches, PC/IR frozen
        bus1.imem_rdata = 32'h0000007F;
        bus1.imem_ack   = 1'b1;
        @(negedge clk);
        bus1.imem_ack = 1'b0;
        for (int c = 0; c < 10 && !bus1.trap; c++) @(negedge clk);
        chk("ill_trap", 32'(bus1.trap), 32'd1);
        chk("ill_cause", 32'(bus1.trap_cause), 32'd1);
        rq = 0;
        bus1.imem_ack = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus1.imem_req || bus1.rf_we || bus1.alu_en || bus1.dmem_req) rq++;
        end
        bus1.imem_ack = 1'b0;
        chk("trap_quiet", rq, 0);
        chk("trap_pc_frozen", bus1.pc, 32'h4);
        chk("trap_ir_frozen", bus1.ir, 32'h0000007F);
        #2 rst_n = 1'b0;
        #1;
        chk("trap_rst_pc", bus1.pc, 32'h0);
        chk("trap_rst_trap", 32'(bus1.trap), 32'd0);
        chk("trap_rst_cause", 32'(bus1.trap_cause), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 32'h0;
        run(tbl[0]);

        // fetch timeout with MEM_TIMEOUT=4
        @(negedge clk);
        rst2 = 1'b1;
        repeat (3) @(negedge clk);
        chk("ito_wait4_trap", 32'(bus2.trap), 32'd0);
        chk("ito_wait4_req", 32'(bus2.imem_req), 32'd1);
        @(negedge clk);
        chk("ito_trap", 32'(bus2.trap), 32'd1);
        chk("ito_cause", 32'(bus2.trap_cause), 32'd2);

        // reset while a load is in MEM drops DMEM_REQ without a clock edge
        rst2 = 1'b0;
        bus2.imem_rdata = 32'h0000A103;
        bus2.alu_result = 32'h10;
        @(negedge clk);
        rst2 = 1'b1;
        bus2.imem_ack = 1'b1;
        @(negedge clk);
        bus2.imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("mem_req", 32'(bus2.dmem_req), 32'd1);
        chk("mem_we", 32'(bus2.dmem_we), 32'd0);
        chk("mem_addr", bus2.dmem_addr, 32'h10);
        @(negedge clk);
        #2 rst2 = 1'b0;
        #1;
        chk("mem_rst_req", 32'(bus2.dmem_req), 32'd0);

        // data timeout: four unanswered MEM cycles then trap cause 3
        @(negedge clk);
        rst2 = 1'b1;
        bus2.imem_ack = 1'b1;
        @(negedge clk);
        bus2.imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("dto_wait4_trap", 32'(bus2.trap), 32'd0);
        chk("dto_wait4_req", 32'(bus2.dmem_req), 32'd1);
        @(negedge clk);
        chk("dto_trap", 32'(bus2.trap), 32'd1);
        chk("dto_cause", 32'(bus2.trap_cause), 32'd3);
        chk("dto_req_drop", 32'(bus2.dmem_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
